// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: latches the instruction word, decodes it into
// registered one-hot operation strobes, drives the memory handshake and PC control.
module control_sequencer #(
    parameter int OPW   = 4,
    parameter int ADDRW = 8,
    parameter int NOPS  = 8,
    parameter int CNTW  = 16,
    localparam int IRW  = OPW + ADDRW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRW-1:0]   ir_in,
    input  logic             mem_ready,
    input  logic             zero_flag,
    output logic             fetch_req,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [NOPS-1:0]  op_onehot,
    output logic             exec_strobe,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADDRW-1:0] addr_out,
    output logic             illegal,
    output logic [CNTW-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_TRAP
    } state_t;

    localparam int unsigned NOPS_U = NOPS;

    state_t         state, next_state;
    logic [IRW-1:0] ir_q;
    logic [OPW-1:0] opc;
    logic           opc_legal;
    logic           is_load, is_store, is_jump, is_jumpz, is_mem_op;
    logic           retire;

    // Opcode decode works from the latched word; only legal opcodes ever reach EXEC/MEM.
    assign opc       = ir_q[IRW-1:ADDRW];
    assign opc_legal = 32'(opc) < NOPS_U;
    assign is_load   = 32'(opc) == 32'd0;
    assign is_store  = 32'(opc) == 32'd1;
    assign is_jump   = 32'(opc) == 32'd4;
    assign is_jumpz  = 32'(opc) == 32'd5;
    assign is_mem_op = is_load | is_store;
    assign addr_out  = ir_q[ADDRW-1:0];

    assign retire = ((state == S_EXEC) && !is_mem_op) || ((state == S_MEM) && mem_ready);

    // NOTE: asynchronous reset in the sensitivity list, and non-blocking (<=) for
    // every flop so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: next_state = opc_legal ? S_EXEC : S_TRAP;
            S_EXEC:   next_state = is_mem_op ? S_MEM : S_FETCH;
            S_MEM:    if (mem_ready) next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            op_onehot <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            if ((state == S_FETCH) && mem_ready) begin
                ir_q <= ir_in;
            end
            if (state == S_DECODE) begin
                if (opc_legal) begin
                    op_onehot <= NOPS'(1) << opc;
                end else begin
                    illegal <= 1'b1;
                end
            end else if (next_state == S_FETCH) begin
                op_onehot <= '0;
            end
            // Saturate rather than wrap so software can detect overflow.
            if (retire && (retired != '1)) begin
                retired <= retired + CNTW'(1);
            end
        end
    end

    always_comb begin
        fetch_req   = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        exec_strobe = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state)
            S_FETCH:  fetch_req = 1'b1;
            S_DECODE: pc_inc = 1'b1;
            S_EXEC: begin
                exec_strobe = 1'b1;
                pc_load     = is_jump | (is_jumpz & zero_flag);
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction phase model with
// randomized programs, memory wait states, traps and asynchronous resets.
module tb_control_sequencer;

    localparam int OPW   = 4;
    localparam int ADDRW = 8;
    localparam int NOPS  = 8;
    localparam int IRW   = OPW + ADDRW;

    logic             clk = 1'b0;
    logic             reset;
    logic [IRW-1:0]   ir_in;
    logic             mem_ready;
    logic             zero_flag;

    logic             fetch_req, pc_inc, pc_load, exec_strobe, mem_req, mem_we, illegal;
    logic [NOPS-1:0]  op_onehot;
    logic [ADDRW-1:0] addr_out;
    logic [15:0]      retired;

    logic             fetch_req_s, pc_inc_s, pc_load_s, exec_strobe_s, mem_req_s, mem_we_s, illegal_s;
    logic [NOPS-1:0]  op_onehot_s;
    logic [ADDRW-1:0] addr_out_s;
    logic [2:0]       retired_s;

    int          checks = 0;
    int          errors = 0;
    int unsigned model_cnt = 0;

    control_sequencer #(.OPW(OPW), .ADDRW(ADDRW), .NOPS(NOPS), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .mem_ready(mem_ready), .zero_flag(zero_flag),
        .fetch_req(fetch_req), .pc_inc(pc_inc), .pc_load(pc_load), .op_onehot(op_onehot),
        .exec_strobe(exec_strobe), .mem_req(mem_req), .mem_we(mem_we), .addr_out(addr_out),
        .illegal(illegal), .retired(retired)
    );

    control_sequencer #(.OPW(OPW), .ADDRW(ADDRW), .NOPS(NOPS), .CNTW(3)) dut_sat (
        .clk(clk), .reset(reset), .ir_in(ir_in), .mem_ready(mem_ready), .zero_flag(zero_flag),
        .fetch_req(fetch_req_s), .pc_inc(pc_inc_s), .pc_load(pc_load_s), .op_onehot(op_onehot_s),
        .exec_strobe(exec_strobe_s), .mem_req(mem_req_s), .mem_we(mem_we_s), .addr_out(addr_out_s),
        .illegal(illegal_s), .retired(retired_s)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic f, input logic pi, input logic pl,
                              input logic ex, input logic mr, input logic mw,
                              input logic [NOPS-1:0] oh);
        check({tag, ".fetch_req"},   32'(fetch_req),   32'(f));
        check({tag, ".pc_inc"},      32'(pc_inc),      32'(pi));
        check({tag, ".pc_load"},     32'(pc_load),     32'(pl));
        check({tag, ".exec_strobe"}, 32'(exec_strobe), 32'(ex));
        check({tag, ".mem_req"},     32'(mem_req),     32'(mr));
        check({tag, ".mem_we"},      32'(mem_we),      32'(mw));
        check({tag, ".op_onehot"},   32'(op_onehot),   32'(oh));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_retired(input string tag);
        check({tag, ".retired"},     32'(retired),   (model_cnt > 32'd65535) ? 32'd65535 : model_cnt);
        check({tag, ".retired_sat"}, 32'(retired_s), (model_cnt > 32'd7) ? 32'd7 : model_cnt);
    endtask

    // Reset may arrive at any point; strobes must drop without waiting for a clock edge.
    task automatic apply_reset(input string tag);
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        ir_in     = '0;
        model_cnt = 0;
        #1;
        check_outs({tag, ".async"}, 0, 0, 0, 0, 0, 0, '0);
        check({tag, ".illegal"},  32'(illegal),  32'd0);
        check({tag, ".addr_out"}, 32'(addr_out), 32'd0);
        check_retired({tag, ".async"});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs({tag, ".idle"}, 0, 0, 0, 0, 0, 0, '0);
        @(negedge clk);
        check_outs({tag, ".first_fetch"}, 1, 0, 0, 0, 0, 0, '0);
    endtask

    // Entered with the DUT in FETCH at a falling edge; leaves it in FETCH again
    // (or in TRAP / freshly reset for the trap and reset-in-MEM cases).
    task automatic do_instr(input logic [3:0] opc, input logic [7:0] addr, input logic zf,
                            input int fwait, input int mwait, input bit rst_in_mem);
        string           t;
        logic [NOPS-1:0] oh;
        logic            exp_load;
        t        = $sformatf("op%0h_%0h", opc, addr);
        oh       = '0;
        exp_load = (opc == 4'd4) || ((opc == 4'd5) && zf);
        for (int i = 0; i < fwait; i++) begin
            mem_ready = 1'b0;
            ir_in     = IRW'($urandom);
            #1;
            check_outs({t, ".fetch_wait"}, 1, 0, 0, 0, 0, 0, '0);
            step();
        end
        mem_ready = 1'b1;
        ir_in     = {opc, addr};
        #1;
        check_outs({t, ".fetch"}, 1, 0, 0, 0, 0, 0, '0);
        step();
        mem_ready = 1'($urandom);
        ir_in     = IRW'($urandom);
        #1;
        check_outs({t, ".decode"}, 0, 1, 0, 0, 0, 0, '0);
        check({t, ".decode.addr_out"}, 32'(addr_out), 32'(addr));
        step();
        if ({1'b0, opc} >= 5'(NOPS)) begin
            for (int i = 0; i < 10; i++) begin
                mem_ready = 1'($urandom);
                zero_flag = 1'($urandom);
                #1;
                check_outs({t, ".trap"}, 0, 0, 0, 0, 0, 0, '0);
                check({t, ".trap.illegal"}, 32'(illegal), 32'd1);
                step();
            end
            return;
        end
        oh[opc]   = 1'b1;
        zero_flag = zf;
        mem_ready = 1'($urandom);
        #1;
        check_outs({t, ".exec"}, 0, 0, exp_load, 1, 0, 0, oh);
        check({t, ".exec.addr_out"}, 32'(addr_out), 32'(addr));
        step();
        zero_flag = 1'($urandom);
        if (opc <= 4'd1) begin
            for (int i = 0; i <= mwait; i++) begin
                mem_ready = (i == mwait);
                #1;
                check_outs({t, ".mem"}, 0, 0, 0, 0, 1, opc == 4'd1, oh);
                check({t, ".mem.addr_out"}, 32'(addr_out), 32'(addr));
                if (rst_in_mem) begin
                    apply_reset({t, ".rst_mem"});
                    check_retired({t, ".rst_mem"});
                    return;
                end
                step();
            end
        end
        model_cnt++;
        mem_ready = 1'b0;
        #1;
        check_outs({t, ".refetch"}, 1, 0, 0, 0, 0, 0, '0);
        check_retired(t);
    endtask

    initial begin
        logic [3:0] ropc;
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        ir_in     = '0;
        apply_reset("por");

        do_instr(4'h2, 8'h15, 1'b0, 0, 0, 0);   // ADD
        do_instr(4'h1, 8'hA0, 1'b0, 0, 3, 0);   // STORE with wait states
        do_instr(4'h5, 8'h33, 1'b1, 0, 0, 0);   // JUMPZ taken
        do_instr(4'h5, 8'h33, 1'b0, 0, 0, 0);   // JUMPZ not taken
        do_instr(4'h0, 8'h7E, 1'b0, 2, 0, 0);   // LOAD after slow fetch
        do_instr(4'h4, 8'hFF, 1'b0, 0, 0, 0);   // JUMP
        do_instr(4'h7, 8'h00, 1'b1, 1, 0, 0);   // RSHIFT

        for (int n = 0; n < 60; n++) begin
            ropc = 4'($urandom_range(0, NOPS - 1));
            do_instr(ropc, 8'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end

        apply_reset("sat");
        for (int n = 0; n < 9; n++) begin
            do_instr(4'h2, 8'(n), 1'b0, 0, 0, 0);
        end

        apply_reset("mid_fetch_pre");
        mem_ready = 1'b0;
        #1;
        check("mid_fetch.fetch_req", 32'(fetch_req), 32'd1);
        apply_reset("mid_fetch");

        do_instr(4'h2, 8'h01, 1'b0, 0, 0, 0);
        do_instr(4'h1, 8'h5A, 1'b0, 0, 4, 1);   // reset lands during MEM

        do_instr(4'hC, 8'h12, 1'b0, 0, 0, 0);   // undefined opcode traps
        apply_reset("clr_trap");
        ropc = 4'($urandom_range(NOPS, 15));
        do_instr(ropc, 8'($urandom), 1'b0, 1, 0, 0);
        apply_reset("clr_trap2");
        do_instr(4'h3, 8'h44, 1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
